// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns (bit0=a .. bit6=g) and digit types.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Pattern -> {valid, nibble}; exact inverse of the display encoder, combinational.
// Anything that is not one of the 16 glyphs (blank included) reads as nibble 0, invalid.
module seg7_decode
  import seg7_pkg::*;
(
  input  seg_t    i_seg,
  output nibble_t o_nib,
  output logic    o_vld
);

  always_comb begin
    o_nib = 4'h0;
    o_vld = 1'b1;
    case (i_seg)
      SEG_0:   o_nib = 4'h0;
      SEG_1:   o_nib = 4'h1;
      SEG_2:   o_nib = 4'h2;
      SEG_3:   o_nib = 4'h3;
      SEG_4:   o_nib = 4'h4;
      SEG_5:   o_nib = 4'h5;
      SEG_6:   o_nib = 4'h6;
      SEG_7:   o_nib = 4'h7;
      SEG_8:   o_nib = 4'h8;
      SEG_9:   o_nib = 4'h9;
      SEG_A:   o_nib = 4'hA;
      SEG_B:   o_nib = 4'hB;
      SEG_C:   o_nib = 4'hC;
      SEG_D:   o_nib = 4'hD;
      SEG_E:   o_nib = 4'hE;
      SEG_F:   o_nib = 4'hF;
      default: o_vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples six 7-segment buses round-robin, debounces each digit over STABLE_SCANS samples and
// reports committed changes at sweep end over valid/ready; outputs freeze while a report waits.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 1,
  parameter int STABLE_SCANS = 3
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [6:0]  HEX0,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX3,
  input  logic [6:0]  HEX4,
  input  logic [6:0]  HEX5,
  output logic [23:0] value,
  output logic [5:0]  digit_valid,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       STABLE   = 4'(STABLE_SCANS);

  seg_t    [NUM_DIGITS-1:0]      w_hex_in;
  seg_t    [NUM_DIGITS-1:0]      r_sync1;
  seg_t    [NUM_DIGITS-1:0]      r_sync2;
  seg_t    [NUM_DIGITS-1:0]      r_last;
  logic    [NUM_DIGITS-1:0][3:0] r_cnt;
  nibble_t [NUM_DIGITS-1:0]      r_com_nib;
  nibble_t [NUM_DIGITS-1:0]      w_com_nib_nxt;
  logic    [NUM_DIGITS-1:0]      r_com_vld;
  logic    [NUM_DIGITS-1:0]      w_com_vld_nxt;
  logic    [DIV_W-1:0]           r_div;
  logic    [2:0]                 r_idx;
  logic    [23:0]                r_value;
  logic    [5:0]                 r_digit_vld;
  logic                          r_out_vld;

  seg_t       w_raw;
  nibble_t    w_dec_nib;
  logic       w_dec_vld;
  logic       w_sample;
  logic       w_sweep_end;
  logic [3:0] w_cnt_nxt;
  logic       w_differs;
  logic       w_load;

  assign w_hex_in    = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign w_sample    = (r_div == DIV_LAST);
  assign w_sweep_end = w_sample && (r_idx == 3'd5);
  assign w_raw       = r_sync2[r_idx];

  seg7_decode u_decode (
    .i_seg (w_raw),
    .o_nib (w_dec_nib),
    .o_vld (w_dec_vld)
  );

  // The sweep-end compare uses the next committed set so digit 5 is reported in its own sweep.
  always_comb begin
    w_cnt_nxt = 4'd1;
    if (w_raw == r_last[r_idx]) begin
      w_cnt_nxt = (r_cnt[r_idx] >= STABLE) ? STABLE : r_cnt[r_idx] + 4'd1;
    end
    w_com_nib_nxt = r_com_nib;
    w_com_vld_nxt = r_com_vld;
    if (w_sample && (w_cnt_nxt == STABLE)) begin
      w_com_nib_nxt[r_idx] = w_dec_nib;
      w_com_vld_nxt[r_idx] = w_dec_vld;
    end
  end

  assign w_differs = ({w_com_nib_nxt, w_com_vld_nxt} != {r_value, r_digit_vld});
  assign w_load    = w_sweep_end && w_differs && (!r_out_vld || out_ready);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_com_nib   <= '0;
      r_com_vld   <= '0;
      r_div       <= '0;
      r_idx       <= '0;
      r_value     <= '0;
      r_digit_vld <= '0;
      r_out_vld   <= 1'b0;
    end else begin
      r_sync1   <= w_hex_in;
      r_sync2   <= r_sync1;
      r_div     <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_com_nib <= w_com_nib_nxt;
      r_com_vld <= w_com_vld_nxt;
      if (w_sample) begin
        r_last[r_idx] <= w_raw;
        r_cnt[r_idx]  <= w_cnt_nxt;
        r_idx         <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end
      if (w_load) begin
        r_value     <= w_com_nib_nxt;
        r_digit_vld <= w_com_vld_nxt;
        r_out_vld   <= 1'b1;
      end else if (out_ready) begin
        r_out_vld   <= 1'b0;
      end
    end
  end

  assign value       = r_value;
  assign digit_valid = r_digit_vld;
  assign out_valid   = r_out_vld;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with default parameters; outputs sampled on the falling edge.
module tb_seg7_reader;
  import seg7_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [6:0]  HEX0 = SEG_BLANK, HEX1 = SEG_BLANK, HEX2 = SEG_BLANK;
  logic [6:0]  HEX3 = SEG_BLANK, HEX4 = SEG_BLANK, HEX5 = SEG_BLANK;
  logic [23:0] value;
  logic [5:0]  digit_valid;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_acc  = 0;
  logic [23:0] acc_val = '0;
  int          cyc = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  seg7_reader dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5),
    .value       (value),
    .digit_valid (digit_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Handshake monitor and a cycle count since reset release (edge k => cyc == k).
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (out_valid && out_ready) begin
        n_acc   <= n_acc + 1;
        acc_val <= value;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_vld(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge CLOCK_50);
      if (out_valid) seen = 1'b1;
    end
  endtask

  bit seen;
  int n0, t0, lat, nvld;

  initial begin
    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(value), 32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);

    // Test 2: blank display never reports
    RESET_N   = 1'b1;
    out_ready = 1'b1;
    nvld = 0;
    repeat (200) begin
      @(negedge CLOCK_50);
      if (out_valid) nvld++;
    end
    check("t2_no_report", 32'(nvld), 32'd0);
    check("t2_value", 32'(value), 32'h0);
    check("t2_digit_valid", 32'(digit_valid), 32'h0);

    // Test 1: F12345, applied so every digit's first new sample falls in one sweep
    @(negedge CLOCK_50);
    while (cyc % 6 != 4) @(negedge CLOCK_50);
    HEX5 = SEG_F; HEX4 = SEG_1; HEX3 = SEG_2; HEX2 = SEG_3; HEX1 = SEG_4; HEX0 = SEG_5;
    t0 = cyc;
    n0 = n_acc;
    wait_vld(60, seen);
    lat = cyc - t0;
    check("t1_seen", 32'(seen), 32'd1);
    check("t1_latency_le38", 32'(lat <= 38), 32'd1);
    check("t1_value", 32'(value), 32'hF12345);
    check("t1_digit_valid", 32'(digit_valid), 32'h3F);
    repeat (100) @(negedge CLOCK_50);
    check("t1_one_report", 32'(n_acc - n0), 32'd1);

    // Test 3: HEX2 flips faster than the stability window
    n0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      HEX2 = (i % 2 == 0) ? SEG_8 : SEG_3;
      repeat (6) @(negedge CLOCK_50);
    end
    repeat (40) @(negedge CLOCK_50);
    check("t3_no_report", 32'(n_acc - n0), 32'd0);
    check("t3_value", 32'(value), 32'hF12345);

    // Test 4: backpressure holds the first report, the later change follows acceptance
    out_ready = 1'b0;
    HEX0 = SEG_A;
    wait_vld(60, seen);
    check("t4_first_seen", 32'(seen), 32'd1);
    check("t4_first_value", 32'(value), 32'hF1234A);
    HEX0 = SEG_7;
    repeat (60) @(negedge CLOCK_50);
    check("t4_held_valid", 32'(out_valid), 32'd1);
    check("t4_held_value", 32'(value), 32'hF1234A);
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    out_ready = 1'b0;
    check("t4_accepted_value", 32'(acc_val), 32'hF1234A);
    wait_vld(20, seen);
    check("t4_second_seen", 32'(seen), 32'd1);
    check("t4_second_value", 32'(value), 32'hF12347);
    check("t4_second_digit_valid", 32'(digit_valid), 32'h3F);
    out_ready = 1'b1;
    @(negedge CLOCK_50);

    // Test 5: illegal glyph on HEX3
    HEX3 = 7'b1010101;
    wait_vld(60, seen);
    check("t5_seen", 32'(seen), 32'd1);
    check("t5_digit_valid", 32'(digit_valid), 32'h37);
    check("t5_value", 32'(value), 32'hF10347);

    // Test 6: reset while a report is pending
    out_ready = 1'b0;
    HEX3 = SEG_2;
    HEX0 = SEG_5;
    wait_vld(60, seen);
    check("t6_pending", 32'(seen), 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("t6_async_out_valid", 32'(out_valid), 32'd0);
    check("t6_async_value", 32'(value), 32'h0);
    check("t6_async_digit_valid", 32'(digit_valid), 32'h0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N   = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 38 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (out_valid && value == 24'hF12345 && digit_valid == 6'h3F) seen = 1'b1;
    end
    check("t6_rereport_le38", 32'(seen), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
